// File: rtl/pll_rst_seq.sv
`default_nettype none
// ============================================================================
//  Module   : pll_rst_seq
//  Purpose  : PLL reset/lock sequencer. Pulses pll_rst, waits for a stable
//             synchronized lock, then releases sys_rst. It retries on lock
//             timeout, enters FAULT after too many failures and re-sequences
//             on lock loss.
//  Options  : PLL_RST_SEQ_LOSS_CNT_EN - enables the saturating lock-loss
//             event counter on loss_cnt. When undefined, loss_cnt is tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module pll_rst_seq #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_STABLE  = 64,
  parameter int LOCK_TIMEOUT = 5000,
  parameter int MAX_RETRIES  = 3
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [2:0] state,
  output logic [7:0] loss_cnt
);

  // One shared counter serves as the ASSERT_RST cycle count, the WAIT_LOCK
  // timer and the STABLE run length, so it is sized for the largest of them.
  localparam int c_CNT_MAX_A = (RST_CYCLES > LOCK_STABLE) ? RST_CYCLES : LOCK_STABLE;
  localparam int c_CNT_MAX   = (c_CNT_MAX_A > LOCK_TIMEOUT) ? c_CNT_MAX_A : LOCK_TIMEOUT;
  localparam int c_CNT_W     = (c_CNT_MAX > 2) ? $clog2(c_CNT_MAX) : 1;

  localparam logic [c_CNT_W-1:0] c_RST_LAST  = c_CNT_W'(RST_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_TMO_LAST  = c_CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [c_CNT_W-1:0] c_STB_LAST  = c_CNT_W'(LOCK_STABLE - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_CNT_ZERO  = '0;
  localparam logic [3:0]         c_RETRY_MAX = 4'(MAX_RETRIES);

  localparam logic [2:0] S_ASSERT_RST = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK  = 3'd1;
  localparam logic [2:0] S_STABLE     = 3'd2;
  localparam logic [2:0] S_RUN        = 3'd3;
  localparam logic [2:0] S_FAULT      = 3'd4;

  logic               r_lk_meta;
  logic               r_lk_s;
  logic [2:0]         r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [3:0]         r_retry;

  logic [2:0]         w_state_nxt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic [3:0]         w_retry_nxt;

  logic               w_pll_rst_nxt;
  logic               w_sys_rst_nxt;
  logic               w_ready_nxt;
  logic               w_fault_nxt;

`ifdef PLL_RST_SEQ_LOSS_CNT_EN
  logic               w_loss_evt;
  logic [7:0]         r_loss;
`endif

  // Two-flop synchronizer: pll_locked is asynchronous to refclk.
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_lk_meta <= 1'b0;
      r_lk_s    <= 1'b0;
    end else begin
      r_lk_meta <= pll_locked;
      r_lk_s    <= r_lk_meta;
    end
  end

  // State register together with the shared counter and the retry count.
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state <= S_ASSERT_RST;
      r_cnt   <= c_CNT_ZERO;
      r_retry <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_retry <= w_retry_nxt;
    end
  end

  // Next-state logic. restart overrides every lock/timeout event, so a
  // coincident timeout never charges a retry.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_retry_nxt = r_retry;
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
    w_loss_evt  = 1'b0;
`endif
    if (restart) begin
      w_state_nxt = S_ASSERT_RST;
      w_cnt_nxt   = c_CNT_ZERO;
      w_retry_nxt = 4'd0;
    end else begin
      case (r_state)
        S_ASSERT_RST: begin
          if (r_cnt == c_RST_LAST) begin
            w_state_nxt = S_WAIT_LOCK;
            w_cnt_nxt   = c_CNT_ZERO;
          end else begin
            w_cnt_nxt   = r_cnt + c_CNT_ONE;
          end
        end
        S_WAIT_LOCK: begin
          if (r_lk_s) begin
            // The sample that ends the wait is the first good lock cycle.
            w_state_nxt = S_STABLE;
            w_cnt_nxt   = c_CNT_ONE;
          end else if (r_cnt == c_TMO_LAST) begin
            w_cnt_nxt = c_CNT_ZERO;
            if (r_retry == c_RETRY_MAX) begin
              w_state_nxt = S_FAULT;
            end else begin
              w_state_nxt = S_ASSERT_RST;
              w_retry_nxt = r_retry + 4'd1;
            end
          end else begin
            w_cnt_nxt = r_cnt + c_CNT_ONE;
          end
        end
        S_STABLE: begin
          if (!r_lk_s) begin
            // A glitch restarts the wait without charging an attempt.
            w_state_nxt = S_WAIT_LOCK;
            w_cnt_nxt   = c_CNT_ZERO;
          end else if (r_cnt == c_STB_LAST) begin
            w_state_nxt = S_RUN;
            w_cnt_nxt   = c_CNT_ZERO;
            w_retry_nxt = 4'd0;
          end else begin
            w_cnt_nxt = r_cnt + c_CNT_ONE;
          end
        end
        S_RUN: begin
          if (!r_lk_s) begin
            w_state_nxt = S_ASSERT_RST;
            w_cnt_nxt   = c_CNT_ZERO;
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
            w_loss_evt  = 1'b1;
`endif
          end
        end
        S_FAULT: begin
          w_state_nxt = S_FAULT;
        end
        default: begin
          w_state_nxt = S_ASSERT_RST;
          w_cnt_nxt   = c_CNT_ZERO;
        end
      endcase
    end
  end

  // Output decode from the current state. It feeds the output register, so
  // every output moves together one cycle behind the internal state.
  always_comb begin
    w_pll_rst_nxt = (r_state == S_ASSERT_RST) || (r_state == S_FAULT);
    w_sys_rst_nxt = (r_state != S_RUN);
    w_ready_nxt   = (r_state == S_RUN);
    w_fault_nxt   = (r_state == S_FAULT);
  end

  // Output register.
  always_ff @(posedge refclk) begin
    if (rst) begin
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      ready     <= 1'b0;
      fault     <= 1'b0;
      retry_cnt <= 4'd0;
      state     <= S_ASSERT_RST;
    end else begin
      pll_rst   <= w_pll_rst_nxt;
      sys_rst   <= w_sys_rst_nxt;
      ready     <= w_ready_nxt;
      fault     <= w_fault_nxt;
      retry_cnt <= r_retry;
      state     <= r_state;
    end
  end

`ifdef PLL_RST_SEQ_LOSS_CNT_EN
  // Saturating lock-loss counter; only rst clears it.
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_loss   <= 8'd0;
      loss_cnt <= 8'd0;
    end else begin
      if (w_loss_evt && (r_loss != 8'hFF)) begin
        r_loss <= r_loss + 8'd1;
      end
      loss_cnt <= r_loss;
    end
  end
`else
  assign loss_cnt = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pll_rst_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pll_rst_seq
//  Purpose  : Self-checking bench for pll_rst_seq. A phase/age reference model
//             predicts every output each cycle; directed scenarios and a
//             random lock/restart/reset pattern drive both.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pll_rst_seq;

  localparam int RC = 4;
  localparam int LS = 8;
  localparam int LT = 20;
  localparam int MR = 2;

  localparam int P_ASSERT = 0;
  localparam int P_WAIT   = 1;
  localparam int P_STABLE = 2;
  localparam int P_RUN    = 3;
  localparam int P_FAULT  = 4;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       restart = 1'b0;
  logic       pll_rst, sys_rst, ready, fault;
  logic [3:0] retry_cnt;
  logic [2:0] state;
  logic [7:0] loss_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: phase, cycles spent in phase, current good-lock run
  int m_phase, m_age, m_run, m_retry, m_loss;
  bit m_s1, m_s2;
  int e_state, e_pll, e_sys, e_ready, e_fault, e_retry, e_loss;

`ifdef PLL_RST_SEQ_LOSS_CNT_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  always #5 refclk = ~refclk;

  pll_rst_seq #(
    .RST_CYCLES  (RC),
    .LOCK_STABLE (LS),
    .LOCK_TIMEOUT(LT),
    .MAX_RETRIES (MR)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .pll_locked(pll_locked),
    .restart   (restart),
    .pll_rst   (pll_rst),
    .sys_rst   (sys_rst),
    .ready     (ready),
    .fault     (fault),
    .retry_cnt (retry_cnt),
    .state     (state),
    .loss_cnt  (loss_cnt)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock edge of the reference model. Outputs reflect the phase held
  // before the edge; the phase then advances by the sequencing rules.
  task automatic model_step(input bit r, input bit rs, input bit lk_in);
    bit lk;
    if (r) begin
      m_phase = P_ASSERT; m_age = 0; m_run = 0; m_retry = 0; m_loss = 0;
      m_s1 = 0; m_s2 = 0;
      e_state = P_ASSERT; e_pll = 1; e_sys = 1; e_ready = 0; e_fault = 0;
      e_retry = 0; e_loss = 0;
      return;
    end
    e_state = m_phase;
    e_pll   = (m_phase == P_ASSERT || m_phase == P_FAULT) ? 1 : 0;
    e_sys   = (m_phase != P_RUN) ? 1 : 0;
    e_ready = (m_phase == P_RUN) ? 1 : 0;
    e_fault = (m_phase == P_FAULT) ? 1 : 0;
    e_retry = m_retry;
    e_loss  = m_loss;
    lk = m_s2;
    m_s2 = m_s1;
    m_s1 = lk_in;
    if (rs) begin
      m_phase = P_ASSERT; m_age = 0; m_retry = 0;
      return;
    end
    case (m_phase)
      P_ASSERT: begin
        m_age++;
        if (m_age == RC) begin m_phase = P_WAIT; m_age = 0; end
      end
      P_WAIT: begin
        m_age++;
        if (lk) begin
          m_phase = P_STABLE; m_run = 1;
        end else if (m_age == LT) begin
          m_age = 0;
          if (m_retry == MR) m_phase = P_FAULT;
          else begin m_retry++; m_phase = P_ASSERT; end
        end
      end
      P_STABLE: begin
        if (lk) begin
          m_run++;
          if (m_run == LS) begin m_phase = P_RUN; m_retry = 0; end
        end else begin
          m_phase = P_WAIT; m_age = 0; m_run = 0;
        end
      end
      P_RUN: begin
        if (!lk) begin
          m_phase = P_ASSERT; m_age = 0;
          if (LOSS_EN && m_loss < 255) m_loss++;
        end
      end
      default: ;
    endcase
  endtask

  task automatic compare_all();
    chk("state",     16'(state),     16'(e_state));
    chk("pll_rst",   16'(pll_rst),   16'(e_pll));
    chk("sys_rst",   16'(sys_rst),   16'(e_sys));
    chk("ready",     16'(ready),     16'(e_ready));
    chk("fault",     16'(fault),     16'(e_fault));
    chk("retry_cnt", 16'(retry_cnt), 16'(e_retry));
    chk("loss_cnt",  16'(loss_cnt),  16'(e_loss));
  endtask

  // Drive inputs on the falling edge, step the model on the rising edge and
  // compare on the next falling edge.
  task automatic cyc(input bit r, input bit rs, input bit lk);
    rst = r; restart = rs; pll_locked = lk;
    @(posedge refclk);
    model_step(r, rs, lk);
    @(negedge refclk);
    compare_all();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_state"}, 16'(state),     16'd0);
    chk({tag, "_pll"},   16'(pll_rst),   16'd1);
    chk({tag, "_sys"},   16'(sys_rst),   16'd1);
    chk({tag, "_ready"}, 16'(ready),     16'd0);
    chk({tag, "_fault"}, 16'(fault),     16'd0);
    chk({tag, "_retry"}, 16'(retry_cnt), 16'd0);
    chk({tag, "_loss"},  16'(loss_cnt),  16'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, pll_hi, got;
    @(negedge refclk);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    check_reset_values("reset");

    // steady lock: pll_rst held for RC cycles, ready after RC+2+LS-1 edges
    cyc(1, 0, 1);
    lat = 0; pll_hi = 0;
    for (int k = 1; k <= 40; k++) begin
      cyc(0, 0, 1);
      if (lat == 0 && pll_rst === 1'b1) pll_hi++;
      if (lat == 0 && ready === 1'b1) lat = k;
    end
    chk("ready_latency", 16'(lat), 16'd13);
    chk("pll_rst_width", 16'(pll_hi), 16'(RC));
    chk("run_sys_rst", 16'(sys_rst), 16'd0);

    // no lock: three failed attempts, then FAULT; restart recovers
    cyc(1, 0, 0);
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      cyc(0, 0, 0);
      if (lat == 0 && fault === 1'b1) lat = k;
    end
    chk("fault_latency", 16'(lat), 16'(3 * (RC + LT) + 1));
    chk("fault_retry", 16'(retry_cnt), 16'(MR));
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    chk("restart_fault", 16'(fault), 16'd0);
    chk("restart_retry", 16'(retry_cnt), 16'd0);

    // lock glitch in STABLE after 5 good cycles
    cyc(1, 0, 1);
    for (int k = 0; k < 7; k++) cyc(0, 0, 1);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    for (int k = 0; k < 30; k++) cyc(0, 0, 1);
    chk("glitch_ready", 16'(ready), 16'd1);

    // lock loss in RUN for 3 cycles, then relock
    for (int k = 0; k < 3; k++) cyc(0, 0, 0);
    for (int k = 0; k < 3; k++) cyc(0, 0, 1);
    chk("loss_cnt_one", 16'(loss_cnt), LOSS_EN ? 16'd1 : 16'd0);
    for (int k = 0; k < 30; k++) cyc(0, 0, 1);
    chk("relock_ready", 16'(ready), 16'd1);

    // restart coincident with the second WAIT_LOCK timeout
    cyc(1, 0, 0);
    for (int k = 0; k < 2 * (RC + LT) - 1; k++) cyc(0, 0, 0);
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    chk("restart_tmo_retry", 16'(retry_cnt), 16'd0);

    // rst in the middle of STABLE
    cyc(1, 0, 1);
    for (int k = 0; k < 8; k++) cyc(0, 0, 1);
    cyc(1, 0, 1);
    check_reset_values("mid_rst");

    // 300 lock-loss events
    for (int i = 0; i < 300; i++) begin
      got = 0;
      for (int k = 0; k < 60 && got == 0; k++) begin
        cyc(0, 0, 1);
        if (ready === 1'b1) got = 1;
      end
      if (got == 0) begin
        chk("loss_loop_ready", 16'd0, 16'd1);
        break;
      end
      for (int k = 0; k < 3; k++) cyc(0, 0, 0);
    end
    cyc(0, 0, 0);
    chk("loss_sat", 16'(loss_cnt), LOSS_EN ? 16'd255 : 16'd0);

    // random lock pattern with sporadic restart and rst
    cyc(1, 0, 0);
    for (int seg = 0; seg < 150; seg++) begin
      bit lv;
      int len;
      lv  = ($urandom_range(0, 3) != 0);
      len = lv ? $urandom_range(1, 30) : $urandom_range(1, 25);
      for (int k = 0; k < len; k++) begin
        cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 63) == 0), lv);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pll_rst_seq.md
PLL_RST_SEQ -- requirements
Module: pll_rst_seq

Interface
REQ-001 Parameter RST_CYCLES, default 16, number of refclk cycles pll_rst is held high per attempt (min 2).
REQ-002 Parameter LOCK_STABLE, default 64, consecutive synchronized-lock cycles required before release (min 2).
REQ-003 Parameter LOCK_TIMEOUT, default 5000, WAIT_LOCK cycles allowed before an attempt fails (min 2).
REQ-004 Parameter MAX_RETRIES, default 3, failed attempts tolerated before FAULT (0..15).
REQ-005 refclk  input  1  sole clock, free-running reference; all logic on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 pll_locked  input  1  PLL lock indication, asynchronous to refclk.
REQ-008 restart  input  1  single-cycle request to re-run the sequence from ASSERT_RST.
REQ-009 pll_rst  output  1  reset to the PLL, active-high.
REQ-010 sys_rst  output  1  reset to the downstream clock domain logic, active-high.
REQ-011 ready  output  1  high only in RUN.
REQ-012 fault  output  1  high only in FAULT.
REQ-013 retry_cnt  output  4  failed attempts since last RUN entry or restart.
REQ-014 state  output  3  state encoding: ASSERT_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4.
REQ-015 loss_cnt  output  8  lock-loss events seen in RUN (see Configuration).

Function
REQ-016 pll_locked SHALL pass through a 2-flop synchronizer (lk_s) before any use; no other input is synchronized.
REQ-017 All outputs SHALL be registered; pll_rst=1 in ASSERT_RST and FAULT, else 0; sys_rst=0 only in RUN.
REQ-018 ASSERT_RST SHALL last exactly RST_CYCLES cycles (entry cycle included), then go to WAIT_LOCK with timer cleared.
REQ-019 WAIT_LOCK: lk_s=1 -> STABLE with stable count 1; timer reaching LOCK_TIMEOUT-1 with lk_s=0 -> failed attempt.
REQ-020 Failed attempt: if retry_cnt==MAX_RETRIES -> FAULT, else retry_cnt+1 and -> ASSERT_RST.
REQ-021 STABLE: lk_s=1 increments count; count==LOCK_STABLE-1 with lk_s=1 -> RUN; lk_s=0 -> WAIT_LOCK, timer cleared, no retry charged.
REQ-022 Entering RUN SHALL clear retry_cnt; ready rises LOCK_STABLE cycles after first lk_s=1 in WAIT_LOCK.
REQ-023 RUN: lk_s=0 SHALL count as a lock-loss event, -> ASSERT_RST next cycle (sys_rst=1, pll_rst=1), retry_cnt unchanged.
REQ-024 FAULT SHALL persist until restart or rst.
REQ-025 restart=1 in any state SHALL force ASSERT_RST next cycle with retry_cnt=0 and ASSERT_RST cycle count restarted.
REQ-026 Priority: rst > restart > timeout/lock events; restart in the same cycle as a timeout SHALL not increment retry_cnt.

Reset
REQ-027 rst=1 SHALL, on the next edge, set state=ASSERT_RST, pll_rst=1, sys_rst=1, ready=0, fault=0, retry_cnt=0, loss_cnt=0, synchronizer flops=0, all counters 0.
REQ-028 rst asserted mid-sequence (any state) SHALL abort it; first post-reset ASSERT_RST lasts full RST_CYCLES.

Configuration
REQ-029 Macro PLL_RST_SEQ_LOSS_CNT_EN defined: loss_cnt increments once per REQ-023 event, saturates at 255, cleared only by rst.
REQ-030 Macro undefined: loss_cnt SHALL be constant 0 and no counter logic synthesized; all other behaviour identical.

Verification (RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=20, MAX_RETRIES=2)
REQ-031 rst released, pll_locked=1 constantly -> pll_rst high 4 cycles; ready=1, sys_rst=0 on edge 4+2+8 (±1 for synchronizer alignment), retry_cnt=0.
REQ-032 pll_locked=0 constantly -> three 24-cycle attempts, retry_cnt 0->1->2, then FAULT: fault=1, pll_rst=1, sys_rst=1; restart pulse -> ASSERT_RST, retry_cnt=0, fault=0.
REQ-033 pll_locked glitches low for 2 cycles in STABLE after 5 good cycles -> back to WAIT_LOCK, retry_cnt unchanged, ready only after 8 fresh consecutive lock cycles.
REQ-034 In RUN, pll_locked drops for 3 cycles -> ready=0, sys_rst=1, pll_rst=1 for 4 cycles, loss_cnt=1 with macro, 0 without; relock returns to RUN.
REQ-035 restart and WAIT_LOCK timeout in the same cycle -> ASSERT_RST, retry_cnt=0; rst mid-STABLE -> all outputs at reset values next edge.
REQ-036 With macro, 300 loss events -> loss_cnt holds 255.
